// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction-memory and ALU control signals between the controller and its datapath
interface alu_ctrl_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [7:0]      imem_data;
    logic [2:0]      alu_sel;
    logic [3:0]      reg_idx;
    logic            reg_we;
    logic            acc_we;
    logic            acc_src;
    logic [3:0]      imm;
    logic            z_in;
    logic            c_in;
    logic            halted;
    modport master (
        output imem_addr, imem_rd, alu_sel, reg_idx, reg_we, acc_we, acc_src, imm, halted,
        input  imem_data, z_in, c_in
    );
    modport slave (
        input  imem_addr, imem_rd, alu_sel, reg_idx, reg_we, acc_we, acc_src, imm, halted,
        output imem_data, z_in, c_in
    );
endinterface

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: multi-cycle fetch/decode/execute controller driving an 8-bit ALU
module alu_ctrl_unit #(
    parameter int PC_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, OPND, OLATCH, HALT} state_t;
    state_t          state, next_state;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [2:0]      alu_sel;
    logic            z_flag, c_flag;
    logic [3:0]      op, dop;
    logic            is_alu, taken;
    assign op      = ir[7:4];
    assign dop     = bus.imem_data[7:4];
    assign is_alu  = !ir[7];
    assign taken   = op == 4'h9 || (op == 4'hA && z_flag) || (op == 4'hB && c_flag);
    assign bus.alu_sel = rst_n ? alu_sel : 3'b000;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else state <= next_state;
    end

    // PC, instruction register, flags and the sticky ALU op select
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= '0;
            ir      <= '0;
            alu_sel <= 3'b000;
            z_flag  <= 1'b0;
            c_flag  <= 1'b0;
        end else begin
            if (state == DECODE) begin
                ir <= bus.imem_data;
                pc <= pc + PC_W'(1);
                if (!bus.imem_data[7]) alu_sel <= bus.imem_data[6:4];
            end
            if (state == EXEC && is_alu && ir[6:5] == 2'b00) c_flag <= bus.c_in;
            if (state == WB && is_alu) z_flag <= bus.z_in;
            if (state == OLATCH) pc <= taken ? bus.imem_data[PC_W-1:0] : pc + PC_W'(1);
        end
    end

    // Next-state decode and per-state strobes; all outputs are held low while reset is asserted
    always_comb begin
        next_state    = state;
        bus.imem_addr = '0;
        bus.imem_rd   = 1'b0;
        bus.reg_idx   = 4'h0;
        bus.reg_we    = 1'b0;
        bus.acc_we    = 1'b0;
        bus.acc_src   = 1'b0;
        bus.imm       = 4'h0;
        bus.halted    = 1'b0;
        case (state)
            FETCH: begin
                bus.imem_rd   = 1'b1;
                bus.imem_addr = pc;
                next_state    = DECODE;
            end
            DECODE: next_state = (!dop[3] || dop == 4'h8 || dop == 4'hC) ? EXEC
                               : (dop == 4'h9 || dop == 4'hA || dop == 4'hB) ? OPND
                               : (dop == 4'hF) ? HALT : FETCH;
            EXEC: begin
                bus.acc_we  = is_alu || op == 4'h8;
                bus.acc_src = op == 4'h8;
                bus.imm     = op == 4'h8 ? ir[3:0] : 4'h0;
                bus.reg_we  = op == 4'hC;
                bus.reg_idx = (is_alu || op == 4'hC) ? ir[3:0] : 4'h0;
                next_state  = WB;
            end
            WB: next_state = FETCH;
            OPND: begin
                bus.imem_rd   = 1'b1;
                bus.imem_addr = pc;
                next_state    = OLATCH;
            end
            OLATCH: next_state = FETCH;
            HALT: bus.halted = 1'b1;
            default: next_state = FETCH;
        endcase
        if (!rst_n) begin
            bus.imem_addr = '0;
            bus.imem_rd   = 1'b0;
            bus.reg_idx   = 4'h0;
            bus.reg_we    = 1'b0;
            bus.acc_we    = 1'b0;
            bus.acc_src   = 1'b0;
            bus.imm       = 4'h0;
            bus.halted    = 1'b0;
        end
    end
endmodule
